// File: rtl/cordic_cos_sin_parallel_pkg.sv
// Shared CORDIC constants: default widths plus elaboration-time generators
// for the arctangent table and the gain-compensated start value XK.
package cordic_pkg;

   localparam int PHI_WDT_DEF = 18;
   localparam int N_DEF       = 13;
   localparam real PI         = 3.14159265358979323846;

   function automatic real pow2(input int e);
      real r;
      r = 1.0;
      for (int k = 0; k < e; k++) r = r * 2.0;
      return r;
   endfunction

   // A[i] = round(atan(2^-i) * 2^w / (2*pi)), in phase-code units
   function automatic int atan_const(input int i, input int w);
      real r;
      r = $atan(1.0 / pow2(i)) * pow2(w) / (2.0 * PI);
      return $rtoi(r + 0.5);
   endfunction

   // XK = round(2^w * prod_{i<n} 1/sqrt(1 + 2^-2i))
   function automatic int xk_const(input int n, input int w);
      real k;
      real p;
      k = 1.0;
      p = 1.0;
      for (int i = 0; i < n; i++) begin
         k = k / $sqrt(1.0 + p * p);
         p = p * 0.5;
      end
      return $rtoi(k * pow2(w) + 0.5);
   endfunction

endpackage

// File: rtl/cordic_cos_sin_parallel_if.sv
// Control, angle and result signals of the CORDIC cos/sin block.
interface cordic_cos_sin_parallel_if
   import cordic_pkg::*;
#(
   parameter int PHI_WDT = PHI_WDT_DEF
);
   logic                      sclr;
   logic                      en;
   logic                      st;
   logic        [PHI_WDT-1:0] phi;
   logic                      rdy;
   logic signed [PHI_WDT-1:0] cos;
   logic signed [PHI_WDT-1:0] sin;

   modport master (output sclr, en, st, phi, input rdy, cos, sin);
   modport slave  (input sclr, en, st, phi, output rdy, cos, sin);
endinterface

// File: rtl/cordic_cos_sin_parallel_stage.sv
// One registered CORDIC micro-rotation with a fixed shift and arctangent constant.
module cordic_stage
   import cordic_pkg::*;
#(
   parameter int XW    = PHI_WDT_DEF + 2,
   parameter int ZW    = PHI_WDT_DEF + 1,
   parameter int SHIFT = 0,
   parameter int ATAN  = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 sclr,
   input  logic                 en,
   input  logic signed [XW-1:0] x_in,
   input  logic signed [XW-1:0] y_in,
   input  logic signed [ZW-1:0] z_in,
   input  logic                 neg_in,
   input  logic                 v_in,
   output logic signed [XW-1:0] x_out,
   output logic signed [XW-1:0] y_out,
   output logic signed [ZW-1:0] z_out,
   output logic                 neg_out,
   output logic                 v_out
);
   localparam logic signed [ZW-1:0] A = ZW'(ATAN);

   logic signed [XW-1:0] x_d, x_q, y_d, y_q;
   logic signed [ZW-1:0] z_d, z_q;
   logic                 neg_d, neg_q, v_d, v_q;

   always_comb begin
      // NOTE: every _d starts from its held value so no path through this block infers a latch.
      x_d   = x_q;
      y_d   = y_q;
      z_d   = z_q;
      neg_d = neg_q;
      v_d   = v_q;
      if (sclr) begin
         x_d   = '0;
         y_d   = '0;
         z_d   = '0;
         neg_d = 1'b0;
         v_d   = 1'b0;
      end else if (en) begin
         neg_d = neg_in;
         v_d   = v_in;
         // Rotate toward z = 0; arithmetic shifts truncate, no rounding here.
         if (!z_in[ZW-1]) begin
            x_d = x_in - (y_in >>> SHIFT);
            y_d = y_in + (x_in >>> SHIFT);
            z_d = z_in - A;
         end else begin
            x_d = x_in + (y_in >>> SHIFT);
            y_d = y_in - (x_in >>> SHIFT);
            z_d = z_in + A;
         end
      end
   end

   // NOTE: state flops use non-blocking assignments so all stages update from pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         x_q   <= '0;
         y_q   <= '0;
         z_q   <= '0;
         neg_q <= 1'b0;
         v_q   <= 1'b0;
      end else begin
         x_q   <= x_d;
         y_q   <= y_d;
         z_q   <= z_d;
         neg_q <= neg_d;
         v_q   <= v_d;
      end
   end

   assign x_out   = x_q;
   assign y_out   = y_q;
   assign z_out   = z_q;
   assign neg_out = neg_q;
   assign v_out   = v_q;

endmodule

// File: rtl/cordic_cos_sin_parallel.sv
// Fully pipelined CORDIC cos/sin: quadrant fold, N micro-rotation stages,
// then sign restore, round-half-up and saturation. One angle per enabled clock.
module cordic_cos_sin_parallel
   import cordic_pkg::*;
#(
   parameter int N       = N_DEF,
   parameter int PHI_WDT = PHI_WDT_DEF
) (
   input  logic                       clk,
   input  logic                       reset,
   cordic_cos_sin_parallel_if.slave   bus
);
   localparam int W  = PHI_WDT;
   localparam int XW = W + 2;
   localparam int ZW = W + 1;

   localparam logic signed [XW-1:0] XK       = XW'(xk_const(N, W));
   localparam logic        [W-1:0]  HALF_TURN = {1'b1, {(W-1){1'b0}}};
   localparam logic signed [XW+1:0] OUT_MAX   = (XW+2)'((1 <<< (W-1)) - 1);

   // Stage 0: fold [pi/2, 3pi/2) onto [-pi/2, pi/2) and remember to negate later.
   logic signed [ZW-1:0] z0_d, z0_q;
   logic                 neg0_d, neg0_q, v0_d, v0_q;
   logic        [W-1:0]  phi_rot;
   logic                 wrap;

   always_comb begin
      z0_d    = z0_q;
      neg0_d  = neg0_q;
      v0_d    = v0_q;
      wrap    = bus.phi[W-1] ^ bus.phi[W-2];
      phi_rot = wrap ? bus.phi + HALF_TURN : bus.phi;
      if (bus.sclr) begin
         z0_d   = '0;
         neg0_d = 1'b0;
         v0_d   = 1'b0;
      end else if (bus.en) begin
         v0_d = bus.st;
         if (bus.st) begin
            neg0_d = wrap;
            z0_d   = {phi_rot[W-1], phi_rot};
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         z0_q   <= '0;
         neg0_q <= 1'b0;
         v0_q   <= 1'b0;
      end else begin
         z0_q   <= z0_d;
         neg0_q <= neg0_d;
         v0_q   <= v0_d;
      end
   end

   // Stages 1..N: x starts at the gain-compensated constant, y at zero.
   logic signed [XW-1:0] x_s   [0:N];
   logic signed [XW-1:0] y_s   [0:N];
   logic signed [ZW-1:0] z_s   [0:N];
   logic                 neg_s [0:N];
   logic                 v_s   [0:N];

   assign x_s[0]   = XK;
   assign y_s[0]   = '0;
   assign z_s[0]   = z0_q;
   assign neg_s[0] = neg0_q;
   assign v_s[0]   = v0_q;

   for (genvar i = 0; i < N; i++) begin : g_stage
      cordic_stage #(
         .XW    (XW),
         .ZW    (ZW),
         .SHIFT (i),
         .ATAN  (atan_const(i, W))
      ) u_stage (
         .clk     (clk),
         .reset   (reset),
         .sclr    (bus.sclr),
         .en      (bus.en),
         .x_in    (x_s[i]),
         .y_in    (y_s[i]),
         .z_in    (z_s[i]),
         .neg_in  (neg_s[i]),
         .v_in    (v_s[i]),
         .x_out   (x_s[i+1]),
         .y_out   (y_s[i+1]),
         .z_out   (z_s[i+1]),
         .neg_out (neg_s[i+1]),
         .v_out   (v_s[i+1])
      );
   end

   // 1.0 = 2^W inside the datapath, full scale = 2^(W-1)-1 at the output.
   function automatic logic signed [W-1:0] round_sat(input logic signed [XW-1:0] v,
                                                     input logic flip);
      logic signed [XW+1:0] t;
      t = {{2{v[XW-1]}}, v};
      if (flip) t = -t;
      t = (t + (XW+2)'(1)) >>> 1;
      if (t > OUT_MAX)       t = OUT_MAX;
      else if (t < -OUT_MAX) t = -OUT_MAX;
      return t[W-1:0];
   endfunction

   logic                 rdy_d, rdy_q;
   logic signed [W-1:0]  cos_d, cos_q, sin_d, sin_q;

   always_comb begin
      rdy_d = rdy_q;
      cos_d = cos_q;
      sin_d = sin_q;
      if (bus.sclr) begin
         rdy_d = 1'b0;
         cos_d = '0;
         sin_d = '0;
      end else if (bus.en) begin
         rdy_d = v_s[N];
         if (v_s[N]) begin
            cos_d = round_sat(x_s[N], neg_s[N]);
            sin_d = round_sat(y_s[N], neg_s[N]);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdy_q <= 1'b0;
         cos_q <= '0;
         sin_q <= '0;
      end else begin
         rdy_q <= rdy_d;
         cos_q <= cos_d;
         sin_q <= sin_d;
      end
   end

   assign bus.rdy = rdy_q;
   assign bus.cos = cos_q;
   assign bus.sin = sin_q;

endmodule

// File: tb/tb_cordic_cos_sin_parallel.sv
// Bench for cordic_cos_sin_parallel: directed angle table, random bursts,
// clock-enable stalls and clears, checked against an integer CORDIC model.
module tb_cordic_cos_sin_parallel;
   localparam int  N   = 13;
   localparam int  W   = 18;
   localparam int  LAT = N + 1;
   localparam int  FS  = 131071;
   localparam int  TOL = 40;
   localparam real PI  = 3.14159265358979323846;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   cordic_cos_sin_parallel_if #(.PHI_WDT(W)) ifc ();

   cordic_cos_sin_parallel #(.N(N), .PHI_WDT(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (ifc)
   );

   typedef struct {
      int phi;
      int exp_cos;
      int exp_sin;
   } vec_t;

   typedef struct {
      int phi;
      int due;
   } sb_t;

   int     n_checks = 0;
   int     n_fail   = 0;
   int     ecnt     = 0;
   int     n_results = 0;
   longint last_c, last_s;
   logic   prev_rdy = 1'b0;
   sb_t    q[$];
   longint atan_tab[N];
   longint xk;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic check_tol(input string name, input longint act, input longint ideal);
      longint diff;
      n_checks++;
      diff = act - ideal;
      if (diff > TOL || diff < -TOL) begin
         n_fail++;
         $display("FAIL %s: got %0d, ideal %0d (tolerance %0d)", name, act, ideal, TOL);
      end
   endtask

   function automatic real p2(input int e);
      real r;
      r = 1.0;
      for (int k = 0; k < e; k++) r = r * 2.0;
      return r;
   endfunction

   function automatic longint clamp(input longint v);
      if (v > FS) return FS;
      if (v < -FS) return -FS;
      return v;
   endfunction

   // Integer model: fold to [-pi/2, pi/2), N rotations, unfold, round half up, saturate.
   function automatic void model(input int phi, output longint c, output longint s);
      longint p, x, y, z, t;
      bit     neg;
      p   = phi;
      neg = ((p >> 17) & 1) != ((p >> 16) & 1);
      if (neg) p = (p + 131072) % 262144;
      z = (p >= 131072) ? p - 262144 : p;
      x = xk;
      y = 0;
      for (int i = 0; i < N; i++) begin
         if (z >= 0) begin
            t = x - (y >>> i);
            y = y + (x >>> i);
            z = z - atan_tab[i];
         end else begin
            t = x + (y >>> i);
            y = y - (x >>> i);
            z = z + atan_tab[i];
         end
         x = t;
      end
      if (neg) begin
         x = -x;
         y = -y;
      end
      c = clamp((x + 1) >>> 1);
      s = clamp((y + 1) >>> 1);
   endfunction

   function automatic int ideal(input real r);
      real v;
      int  n;
      v = r * 131072.0;
      n = (v < 0.0) ? -$rtoi(-v + 0.5) : $rtoi(v + 0.5);
      return int'(clamp(longint'(n)));
   endfunction

   // One clock: note what the DUT saw at the edge, then check outputs 1 time unit later.
   task automatic cycle();
      logic         en_w, st_w, sclr_w;
      logic [W-1:0] phi_w;
      sb_t          e;
      longint       c, s, ac, as_;
      @(posedge clk);
      en_w   = ifc.en;
      st_w   = ifc.st;
      sclr_w = ifc.sclr;
      phi_w  = ifc.phi;
      #1;
      ac  = longint'($signed(ifc.cos));
      as_ = longint'($signed(ifc.sin));
      if (sclr_w) begin
         q.delete();
         check("sclr_rdy", longint'(ifc.rdy), 0);
         check("sclr_cos", ac, 0);
         check("sclr_sin", as_, 0);
      end else if (en_w) begin
         ecnt++;
         if (st_w) q.push_back('{int'(phi_w), ecnt + LAT});
         if (ifc.rdy) begin
            if (q.size() == 0) begin
               check("unexpected_rdy", 1, 0);
            end else begin
               e = q.pop_front();
               check("latency", ecnt, e.due);
               model(e.phi, c, s);
               check($sformatf("cos phi=%0d", e.phi), ac, c);
               check($sformatf("sin phi=%0d", e.phi), as_, s);
               check("full_scale", longint'(ac >= -FS && as_ >= -FS), 1);
               last_c = ac;
               last_s = as_;
               n_results++;
            end
         end else if (q.size() > 0 && q[0].due <= ecnt) begin
            check("missing_rdy", 0, 1);
            void'(q.pop_front());
         end
      end else begin
         check("hold_rdy", longint'(ifc.rdy), longint'(prev_rdy));
      end
      prev_rdy = ifc.rdy;
   endtask

   task automatic drain();
      ifc.st = 1'b0;
      ifc.en = 1'b1;
      for (int i = 0; i < 4 * N + 20 && q.size() > 0; i++) cycle();
      check("drain_timeout", q.size(), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[10];
      int   phis[10];
      int   base, exp_cnt;
      real  p, ang;

      p = 1.0;
      for (int i = 0; i < N; i++) begin
         atan_tab[i] = longint'($rtoi($atan(p) * p2(W) / (2.0 * PI) + 0.5));
         p = p * 0.5;
      end
      p = 1.0;
      ang = 1.0;
      for (int i = 0; i < N; i++) begin
         ang = ang / $sqrt(1.0 + p * p);
         p = p * 0.5;
      end
      xk = longint'($rtoi(ang * p2(W) + 0.5));

      phis = '{0, 65536, 131072, 196608, 65535, 131071, 262143, 32768, 1, 229376};
      for (int i = 0; i < 10; i++) begin
         ang = 2.0 * PI * real'(phis[i]) / p2(W);
         vecs[i] = '{phis[i], ideal($cos(ang)), ideal($sin(ang))};
      end

      reset    = 1'b0;
      ifc.sclr = 1'b0;
      ifc.en   = 1'b1;
      ifc.st   = 1'b0;
      ifc.phi  = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_rdy", longint'(ifc.rdy), 0);
      check("reset_cos", longint'($signed(ifc.cos)), 0);
      check("reset_sin", longint'($signed(ifc.sin)), 0);
      reset = 1'b1;

      // Directed angles: bit-exact via the scoreboard, then closeness to true cos/sin.
      for (int i = 0; i < 10; i++) begin
         base    = n_results;
         ifc.st  = 1'b1;
         ifc.phi = W'(vecs[i].phi);
         cycle();
         drain();
         check($sformatf("result_count phi=%0d", vecs[i].phi), n_results - base, 1);
         check_tol($sformatf("cos_ideal phi=%0d", vecs[i].phi), last_c, vecs[i].exp_cos);
         check_tol($sformatf("sin_ideal phi=%0d", vecs[i].phi), last_s, vecs[i].exp_sin);
      end

      // 20 back-to-back angles: consecutive results in order.
      base = n_results;
      for (int i = 0; i < 20; i++) begin
         ifc.st  = 1'b1;
         ifc.phi = W'($urandom);
         cycle();
      end
      drain();
      check("burst_count", n_results - base, 20);

      // Burst with the clock enable toggling.
      base    = n_results;
      exp_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         ifc.en  = 1'($urandom_range(0, 1));
         ifc.st  = 1'b1;
         ifc.phi = W'($urandom);
         if (ifc.en) exp_cnt++;
         cycle();
      end
      drain();
      check("stall_burst_count", n_results - base, exp_cnt);

      // Synchronous clear mid-burst: nothing stale may emerge afterwards.
      base = n_results;
      for (int i = 0; i < 8; i++) begin
         ifc.st  = 1'b1;
         ifc.phi = W'($urandom);
         cycle();
      end
      ifc.sclr = 1'b1;
      ifc.en   = 1'b0;
      cycle();
      ifc.sclr = 1'b0;
      ifc.en   = 1'b1;
      ifc.st   = 1'b0;
      repeat (N + 6) cycle();
      check("sclr_no_stale", n_results - base, 0);

      // Asynchronous reset mid-burst.
      base = n_results;
      for (int i = 0; i < 10; i++) begin
         ifc.st  = 1'b1;
         ifc.phi = W'($urandom);
         cycle();
      end
      ifc.st = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      check("async_rdy", longint'(ifc.rdy), 0);
      check("async_cos", longint'($signed(ifc.cos)), 0);
      check("async_sin", longint'($signed(ifc.sin)), 0);
      q.delete();
      prev_rdy = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      repeat (N + 6) cycle();
      check("reset_no_stale", n_results - base, 0);

      // Random sparse traffic with random stalls.
      base    = n_results;
      exp_cnt = 0;
      for (int i = 0; i < 300; i++) begin
         ifc.en  = ($urandom_range(0, 3) != 0);
         ifc.st  = 1'($urandom_range(0, 1));
         ifc.phi = W'($urandom);
         if (ifc.en && ifc.st) exp_cnt++;
         cycle();
      end
      drain();
      check("random_count", n_results - base, exp_cnt);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cordic_cos_sin_parallel.md
# cordic_cos_sin_parallel

Computes cosine and sine of an input phase angle with the CORDIC rotation algorithm, fully pipelined (one new angle per enabled clock, result after N+2 enabled clocks). It is the parallel back end behind the top-level `cordicCosSin` selector, which picks this block or the serial sibling `cordic_cos_sin_serial` via CORDIC_TYPE. Both share one port list and one bit-accurate arithmetic definition.

## Interface
- N, 13: number of CORDIC micro-rotations (pipeline stages), 1..PHI_WDT.
- PHI_WDT, 18: width of input angle and of each output.
- clk  in  1  single clock, all registers rising-edge.
- reset  in  1  asynchronous, active-low; clears all registers.
- sclr  in  1  synchronous clear; same effect as reset; priority over en.
- en  in  1  clock enable; when low, every register holds (sclr excepted).
- st  in  1  start: phi is valid this cycle.
- phi  in  PHI_WDT  angle, 2^PHI_WDT codes per 2π; unsigned [0,2π) or signed [−π,π) (same bits).
- rdy  out  1  one-cycle pulse per result.
- cos, sin  out  PHI_WDT signed  results, full scale ±(2^(PHI_WDT−1)−1).

## Operation
- W = PHI_WDT. x, y: signed W+2 bits, 1.0 = 2^W. z: signed W+1 bits, angle units as phi.
- Stage 0 (register on st): if phi[W−1]^phi[W−2] (angle in [π/2,3π/2)), add 2^(W−1) to phi (subtract π) and set neg=1; else neg=0. z = sign-extended result (range [−π/2,π/2)); x = XK, y = 0.
- XK = round(2^W · Π_{i=0..N−1} 1/sqrt(1+2^−2i)) (≈0.60725·2^W), elaboration-time constant.
- Stage i+1, i=0..N−1: d = (z≥0)?+1:−1; x' = x − d·(y>>>i); y' = y + d·(x>>>i); z' = z − d·A[i]; A[i] = round(atan(2^−i)·2^W/(2π)). Arithmetic shifts, truncation, no rounding inside iterations.
- Stage N+1: negate x,y if neg; cos = sat(round(x/2)), sin = sat(round(y/2)); round half up (add 1 then >>>1); saturate to ±(2^(W−1)−1).
- Valid bit travels with data; rdy = valid out of stage N+1. cos/sin registers load only when that valid is 1, else hold.
- Reset/sclr: rdy=0, cos=0, sin=0, all stage data and valid bits 0. Reset mid-computation discards all in-flight angles.

## Timing
- Latency: st sampled at enabled edge k → rdy=1 and cos/sin valid after enabled edge k+N+1 (N+2 enabled clocks including the capture).
- Throughput: one angle per enabled clock; back-to-back st produces back-to-back rdy in order.
- en low: pipeline frozen, rdy held at its current value; each result counts enabled cycles only.
- Serial sibling: FSM IDLE → ITER(N cycles) → OUT → IDLE; st accepted only in IDLE (ignored while busy), same N+2 latency, same bit-exact results.

## Structure
- Package `cordic_pkg`: functions computing A[i] table and XK from N, W (real math at elaboration); angle/datapath width localparams.
- Sub-module `cordic_stage` (one micro-rotation, parameter shift i, constant A[i]) instantiated N times via generate; serial variant reuses the same arithmetic with a variable shift.

## Test plan
- Defaults, phi=0 → after 15 clocks rdy=1, cos≈131071, sin≈0 (|err| ≤ 40 LSB).
- phi=65536 (π/2) → cos≈0, sin≈131071; phi=131072 (π) → cos≈−131071, sin≈0; phi=196608 → sin≈−131071.
- Sweep all quadrants plus boundaries 65535/65536, 131071/131072, 262143; compare bit-exact against the integer model above; no output exceeds ±131071.
- st high 20 consecutive cycles with distinct phi → 20 consecutive rdy pulses, results in order.
- en toggled 50% during a burst → results identical, rdy delayed by stalled cycles; sclr or reset asserted mid-burst → rdy, cos, sin = 0, no stale rdy afterwards.
- Serial build: st during busy ignored; single result after 15 clocks matches parallel bit-exactly.
